udt_tx_scheduler: RTL
=====================

Name: udt_tx_scheduler

Overview:
- Transmit-side packet scheduler for the UDT core, the counterpart to the receive decoder.
- Merges two AXI-Stream packet sources into the single UDP transmit stream: control packets (Handshake/Keep-live/ACK/ACK2/NAK/CLOSE, already encoded) and data packets.
- Grants whole packets only. Control has priority, guarded against starving data. Data packets are paced by the congestion-control send period (inter-packet gap in cycles).

Parameters:
- C_S_AXI_DATA_WIDTH, 32: stream data width in bits; tkeep width is C_S_AXI_DATA_WIDTH/8.
- MAX_CTRL_BURST, 4: maximum consecutive control packets granted while an eligible data packet waits; 0 gives strict control priority.
- GAP_W, 32: width of the send-period / gap counter.

Ports:
- core_clk  in  1  clock.
- core_rst_n  in  1  reset; synchronous, active-low.
- ctrl_tdata  in  C_S_AXI_DATA_WIDTH  control packet data.
- ctrl_tkeep  in  C_S_AXI_DATA_WIDTH/8  control byte enables.
- ctrl_tvalid  in  1  control beat valid.
- ctrl_tlast  in  1  control packet end.
- ctrl_tready  out  1  control beat accepted.
- data_tdata  in  C_S_AXI_DATA_WIDTH  data packet data.
- data_tkeep  in  C_S_AXI_DATA_WIDTH/8  data byte enables.
- data_tvalid  in  1  data beat valid.
- data_tlast  in  1  data packet end.
- data_tready  out  1  data beat accepted.
- out_tdata  out  C_S_AXI_DATA_WIDTH  merged UDP payload.
- out_tkeep  out  C_S_AXI_DATA_WIDTH/8  merged byte enables.
- out_tvalid  out  1  merged beat valid.
- out_tlast  out  1  merged packet end.
- out_tready  in  1  downstream ready.
- snd_period  in  GAP_W  data inter-packet gap in cycles; sampled at each data-packet end.
- busy  out  1  a packet is granted (state is not IDLE).

Behaviour:
- States: IDLE, CTRL, DATA.
- Reset (core_rst_n low at a clock edge):
  - state IDLE; gap_cnt 0; burst_cnt 0.
  - ctrl_tready, data_tready, out_tvalid, out_tlast and busy all 0; out_tdata and out_tkeep 0.
- Data eligibility: data_elig = data_tvalid && gap_cnt==0.
- IDLE arbitration (one cycle; the decision is registered):
  - data_elig && MAX_CTRL_BURST!=0 && burst_cnt>=MAX_CTRL_BURST -> DATA.
  - else ctrl_tvalid -> CTRL.
  - else data_elig -> DATA.
  - else stay in IDLE.
- CTRL and DATA (zero-latency pass-through of the granted source):
  - out_t* = source t*; source tready = out_tready; the other source's tready = 0.
  - On a beat with out_tvalid && out_tready && out_tlast, return to IDLE next cycle.
  - Minimum one idle/arbitration cycle between packets.
  - A source may drop tvalid mid-packet; grant is held until tlast, with no timeout.
- Pacing:
  - At a data tlast handshake, gap_cnt loads snd_period.
  - Otherwise gap_cnt decrements by 1 per cycle while nonzero, including during CTRL packets.
  - snd_period==0 means back-to-back data.
  - A snd_period change mid-gap has no effect until the next load.
- Starvation guard:
  - At a control tlast handshake, burst_cnt increments (saturating at MAX_CTRL_BURST) if data_elig was 1 at that packet's grant.
  - burst_cnt clears when DATA is granted, or in IDLE when data_tvalid==0.
- Simultaneous events: a gap reaching 0 in the same cycle as an IDLE decision does not make data eligible until the next cycle, because eligibility uses the registered gap_cnt.
- Reset mid-packet:
  - Grant is dropped and the packet is truncated without tlast.
  - Downstream and sources share core_rst_n and are reset together.

Optional Feature:
- Macro UDT_TX_STATS_EN.
- Defined:
  - Adds outputs ctrl_pkt_cnt[31:0] and data_pkt_cnt[31:0], counting completed packets (tlast handshakes) per source.
  - Counters wrap modulo 2^32 and reset to 0.
  - Adds gap_stall_cnt[31:0], incrementing each cycle data_tvalid && gap_cnt!=0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single 3-beat control packet, out_tready=1 -> out carries identical beats 1 cycle after tvalid; tlast on beat 3; ctrl_tready low during IDLE cycle; busy high for 3 cycles.
- Both sources valid at the same time, MAX_CTRL_BURST=4, snd_period=0 -> control packet first, then data; no interleaving even with out_tready toggling 1/0 each cycle.
- Continuous control stream plus waiting data, MAX_CTRL_BURST=2 -> order C,C,D,C,C,D; with MAX_CTRL_BURST=0, data never granted while control valid.
- snd_period=10, data continuously valid -> data tlast handshakes exactly 12 cycles apart (10 gap + arbitration + 1-beat packet); a control packet inside the gap is granted immediately.
- core_rst_n low for 1 cycle mid-data-packet -> next cycle all tready/out_tvalid 0, state IDLE, gap_cnt 0; the next data packet is granted without gap.
- With UDT_TX_STATS_EN: 5 control + 3 data packets -> ctrl_pkt_cnt=5, data_pkt_cnt=3; gap_stall_cnt equals counted stalled cycles.

Source files
------------

// File: rtl/udt_tx_scheduler.sv
// -----------------------------------------------------------------------------
// udt_tx_scheduler
//   Transmit-side packet scheduler for the UDT core. Merges the control packet
//   stream (Handshake/Keep-alive/ACK/ACK2/NAK/CLOSE, already encoded) and the
//   data packet stream into the single UDP transmit stream.
//
//   - Whole packets are granted; an IDLE cycle between packets does the
//     arbitration and registers the decision.
//   - Control has priority, but after MAX_CTRL_BURST consecutive control
//     packets granted while data was eligible, a waiting data packet wins.
//     MAX_CTRL_BURST = 0 means strict control priority.
//   - Data packets are paced: at each data tlast handshake the gap counter
//     loads snd_period and counts down; data is eligible only at gap 0.
//
// Ports
//   core_clk, core_rst_n     clock, synchronous active-low reset
//   ctrl_t*                  control packet source (AXI-Stream slave)
//   data_t*                  data packet source (AXI-Stream slave)
//   out_t*                   merged stream (AXI-Stream master), zero-latency
//                            pass-through of the granted source
//   snd_period               data inter-packet gap in cycles
//   busy                     a packet is currently granted
//
// Optional feature (macro UDT_TX_STATS_EN)
//   ctrl_pkt_cnt, data_pkt_cnt  completed packets per source (wrap mod 2^32)
//   gap_stall_cnt               cycles with data_tvalid while the gap runs
// -----------------------------------------------------------------------------
module udt_tx_scheduler #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int MAX_CTRL_BURST     = 4,
    parameter int GAP_W              = 32
) (
    input  logic                            core_clk,
    input  logic                            core_rst_n,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_tdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] ctrl_tkeep,
    input  logic                            ctrl_tvalid,
    input  logic                            ctrl_tlast,
    output logic                            ctrl_tready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   data_tdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] data_tkeep,
    input  logic                            data_tvalid,
    input  logic                            data_tlast,
    output logic                            data_tready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   out_tdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] out_tkeep,
    output logic                            out_tvalid,
    output logic                            out_tlast,
    input  logic                            out_tready,
    input  logic [GAP_W-1:0]                snd_period,
    output logic                            busy
`ifdef UDT_TX_STATS_EN
    ,
    output logic [31:0]                     ctrl_pkt_cnt,
    output logic [31:0]                     data_pkt_cnt,
    output logic [31:0]                     gap_stall_cnt
`endif
);

    localparam int BURST_W = (MAX_CTRL_BURST > 0) ? $clog2(MAX_CTRL_BURST + 1) : 1;
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_CTRL_BURST);
    localparam bit BURST_ON = (MAX_CTRL_BURST != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CTRL = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic                 elig_at_grant_q, elig_at_grant_d;
    logic                 busy_q, busy_d;

    logic                 data_elig;
    logic                 ctrl_done;
    logic                 data_done;

    // Eligibility uses the registered gap, so a gap expiring this cycle only
    // makes data eligible on the following cycle.
    assign data_elig = data_tvalid && (gap_cnt_q == '0);
    assign ctrl_done = (state_q == S_CTRL) && ctrl_tvalid && out_tready && ctrl_tlast;
    assign data_done = (state_q == S_DATA) && data_tvalid && out_tready && data_tlast;

    // Next-state logic: arbitration, pacing and starvation guard.
    always_comb begin
        state_d         = state_q;
        burst_cnt_d     = burst_cnt_q;
        elig_at_grant_d = elig_at_grant_q;

        case (state_q)
            S_IDLE: begin
                if (!data_tvalid) begin
                    burst_cnt_d = '0;
                end
                if (data_elig && BURST_ON && (burst_cnt_q == BURST_MAX)) begin
                    state_d     = S_DATA;
                    burst_cnt_d = '0;
                end else if (ctrl_tvalid) begin
                    state_d         = S_CTRL;
                    elig_at_grant_d = data_elig;
                end else if (data_elig) begin
                    state_d     = S_DATA;
                    burst_cnt_d = '0;
                end
            end
            S_CTRL: begin
                if (ctrl_done) begin
                    state_d = S_IDLE;
                    // Only control packets that actually held off an eligible
                    // data packet count towards the burst limit.
                    if (elig_at_grant_q && (burst_cnt_q != BURST_MAX)) begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (data_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The gap keeps counting in every state, including during control.
        if (data_done) begin
            gap_cnt_d = snd_period;
        end else if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - 1'b1;
        end else begin
            gap_cnt_d = gap_cnt_q;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            state_q         <= S_IDLE;
            gap_cnt_q       <= '0;
            burst_cnt_q     <= '0;
            elig_at_grant_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            gap_cnt_q       <= gap_cnt_d;
            burst_cnt_q     <= burst_cnt_d;
            elig_at_grant_q <= elig_at_grant_d;
            busy_q          <= busy_d;
        end
    end

    // Pass-through of the granted source; everything is quiet in IDLE.
    always_comb begin
        out_tdata   = '0;
        out_tkeep   = '0;
        out_tvalid  = 1'b0;
        out_tlast   = 1'b0;
        ctrl_tready = 1'b0;
        data_tready = 1'b0;
        case (state_q)
            S_CTRL: begin
                out_tdata   = ctrl_tdata;
                out_tkeep   = ctrl_tkeep;
                out_tvalid  = ctrl_tvalid;
                out_tlast   = ctrl_tlast;
                ctrl_tready = out_tready;
            end
            S_DATA: begin
                out_tdata   = data_tdata;
                out_tkeep   = data_tkeep;
                out_tvalid  = data_tvalid;
                out_tlast   = data_tlast;
                data_tready = out_tready;
            end
            default: ;
        endcase
    end

    assign busy = busy_q;

`ifdef UDT_TX_STATS_EN
    logic [31:0] ctrl_pkt_cnt_q, ctrl_pkt_cnt_d;
    logic [31:0] data_pkt_cnt_q, data_pkt_cnt_d;
    logic [31:0] gap_stall_cnt_q, gap_stall_cnt_d;

    always_comb begin
        ctrl_pkt_cnt_d  = ctrl_pkt_cnt_q;
        data_pkt_cnt_d  = data_pkt_cnt_q;
        gap_stall_cnt_d = gap_stall_cnt_q;
        if (ctrl_done) begin
            ctrl_pkt_cnt_d = ctrl_pkt_cnt_q + 32'd1;
        end
        if (data_done) begin
            data_pkt_cnt_d = data_pkt_cnt_q + 32'd1;
        end
        if (data_tvalid && (gap_cnt_q != '0)) begin
            gap_stall_cnt_d = gap_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            ctrl_pkt_cnt_q  <= '0;
            data_pkt_cnt_q  <= '0;
            gap_stall_cnt_q <= '0;
        end else begin
            ctrl_pkt_cnt_q  <= ctrl_pkt_cnt_d;
            data_pkt_cnt_q  <= data_pkt_cnt_d;
            gap_stall_cnt_q <= gap_stall_cnt_d;
        end
    end

    assign ctrl_pkt_cnt  = ctrl_pkt_cnt_q;
    assign data_pkt_cnt  = data_pkt_cnt_q;
    assign gap_stall_cnt = gap_stall_cnt_q;
`endif

endmodule
